// File: rtl/top_pkg.sv
// Field map and shared constants for the top result vector.
// The accumulator/counter fields only carry state when TOP_ACC_EN is defined.
package top_pkg;

  localparam int A_W = 22;
  localparam int B_W = 18;
  localparam int C_W = 22;
  localparam int D_W = 21;

  localparam int IN_LSB   = 0;
  localparam int IN_W     = A_W + B_W + C_W + D_W;
  localparam int SUM_LSB  = 83;
  localparam int SUM_W    = 23;
  localparam int DIFF_LSB = 106;
  localparam int DIFF_W   = 23;
  localparam int PROD_LSB = 129;
  localparam int PROD_W   = 32;
  localparam int XOR_LSB  = 161;
  localparam int XOR_W    = 22;
  localparam int MUX_LSB  = 183;
  localparam int MUX_W    = 22;
  localparam int FLAG_LSB = 205;
  localparam int FLAG_W   = 4;
  localparam int POP_LSB  = 209;
  localparam int POP_W    = 7;
  localparam int ACC_LSB  = 216;
  localparam int ACC_W    = 48;
  localparam int CNT_LSB  = 264;
  localparam int CNT_W    = 16;
  localparam int HIST_LSB = 280;
  localparam int HIST_W   = IN_W;
  localparam int CHK_LSB  = 363;
  localparam int CHK_W    = 22;
  localparam int Y_W      = 385;

  // Flag bit indices within the 4-bit flag field.
  localparam int FLAG_EQ   = 3;
  localparam int FLAG_LT   = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  function automatic logic [CHK_W-1:0] rotl1(input logic [CHK_W-1:0] v);
    return {v[CHK_W-2:0], v[CHK_W-1]};
  endfunction

endpackage

// File: rtl/top_popcount.sv
// Combinational count of set bits over the 83-bit packed operand vector.
module top_popcount
  import top_pkg::*;
(
  input  logic [IN_W-1:0]  din,
  output logic [POP_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < IN_W; i++) begin
      count = count + POP_W'(din[i]);
    end
  end

endmodule

// File: rtl/top.sv
// Registered arithmetic/logic result vector with checksum and input history.
// Define TOP_ACC_EN to build the 48-bit accumulator and 16-bit cycle counter.
module top
  import top_pkg::*;
#(
  parameter logic [CHK_W-1:0] CHK_SEED = 22'h000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [A_W-1:0]   wire0,
  input  logic [B_W-1:0]   wire1,
  input  logic [C_W-1:0]   wire2,
  input  logic [D_W-1:0]   wire3,
  output logic [Y_W-1:0]   y
);

  logic [IN_W-1:0]   in_vec;
  logic [POP_W-1:0]  pop;

  logic [IN_W-1:0]   in_q, in_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DIFF_W-1:0] diff_q, diff_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [XOR_W-1:0]  xor_q, xor_d;
  logic [MUX_W-1:0]  mux_q, mux_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic [POP_W-1:0]  pop_q, pop_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [CHK_W-1:0]  chk_q, chk_d;
`ifdef TOP_ACC_EN
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  assign in_vec = {wire3, wire2, wire1, wire0};

  top_popcount u_popcount (
    .din   (in_vec),
    .count (pop)
  );

  always_comb begin
    in_d   = in_vec;
    sum_d  = {1'b0, wire0} + {1'b0, wire2};
    diff_d = {{(DIFF_W-D_W){wire3[D_W-1]}}, wire3} - {{(DIFF_W-B_W){1'b0}}, wire1};
    prod_d = {16'b0, wire0[15:0]} * {16'b0, wire1[15:0]};
    xor_d  = wire0 ^ wire2;
    mux_d  = wire3[D_W-1] ? wire0 : wire2;
    flag_d = '0;
    flag_d[FLAG_EQ]   = (wire0 == wire2);
    flag_d[FLAG_LT]   = (wire0 < wire2);
    flag_d[FLAG_NEG]  = wire3[D_W-1];
    flag_d[FLAG_ZERO] = (wire1 == '0);
    pop_d  = pop;
    // History is the packed-input field as it stood before this edge.
    hist_d = in_q;
    chk_d  = rotl1(chk_q) ^ wire0 ^ wire2;
`ifdef TOP_ACC_EN
    acc_d  = acc_q + {{(ACC_W-D_W){wire3[D_W-1]}}, wire3};
    cnt_d  = cnt_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= '0;
      sum_q  <= '0;
      diff_q <= '0;
      prod_q <= '0;
      xor_q  <= '0;
      mux_q  <= '0;
      flag_q <= '0;
      pop_q  <= '0;
      hist_q <= '0;
      chk_q  <= CHK_SEED;
`ifdef TOP_ACC_EN
      acc_q  <= '0;
      cnt_q  <= '0;
`endif
    end else begin
      in_q   <= in_d;
      sum_q  <= sum_d;
      diff_q <= diff_d;
      prod_q <= prod_d;
      xor_q  <= xor_d;
      mux_q  <= mux_d;
      flag_q <= flag_d;
      pop_q  <= pop_d;
      hist_q <= hist_d;
      chk_q  <= chk_d;
`ifdef TOP_ACC_EN
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
`endif
    end
  end

`ifdef TOP_ACC_EN
  assign y = {chk_q, hist_q, cnt_q, acc_q, pop_q, flag_q, mux_q, xor_q,
              prod_q, diff_q, sum_q, in_q};
`else
  assign y = {chk_q, hist_q, {(ACC_W+CNT_W){1'b0}}, pop_q, flag_q, mux_q, xor_q,
              prod_q, diff_q, sum_q, in_q};
`endif

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: a spec-level model queues expected y per edge,
// a monitor pops and compares field by field; directed constant checks on top.
module tb_top;

  localparam logic [21:0] SEED = 22'h2A5C3;

  logic         clk;
  logic         rst;
  logic [21:0]  wire0;
  logic [17:0]  wire1;
  logic [21:0]  wire2;
  logic [20:0]  wire3;
  logic [384:0] y;

  int checks   = 0;
  int failures = 0;
  bit verbose  = 1'b1;

  logic [384:0] exp_q[$];

  // Reference state, kept in plain arithmetic terms.
  logic [47:0] m_acc;
  int          m_cnt;
  logic [82:0] m_prev;
  logic [21:0] m_chk;

  top #(.CHK_SEED(SEED)) dut (
    .clk   (clk),
    .rst   (rst),
    .wire0 (wire0),
    .wire1 (wire1),
    .wire2 (wire2),
    .wire3 (wire3),
    .y     (y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input bit r);
    logic [384:0] e;
    int sd, d, s;
    logic [31:0] p;
    e = '0;
    if (r) begin
      m_acc  = '0;
      m_cnt  = 0;
      m_prev = '0;
      m_chk  = SEED;
      e[384:363] = SEED;
    end else begin
      sd = int'($signed(wire3));
      s  = int'(wire0) + int'(wire2);
      d  = sd - int'(wire1);
      p  = 32'(wire0[15:0]) * 32'(wire1[15:0]);
      e[82:0]    = {wire3, wire2, wire1, wire0};
      e[105:83]  = s[22:0];
      e[128:106] = d[22:0];
      e[160:129] = p;
      e[182:161] = wire0 ^ wire2;
      e[204:183] = (sd < 0) ? wire0 : wire2;
      e[208:205] = {wire0 == wire2, wire0 < wire2, sd < 0, wire1 == 18'd0};
      e[215:209] = 7'($countones({wire3, wire2, wire1, wire0}));
      m_acc = m_acc + 48'(longint'(sd));
      m_cnt = (m_cnt + 1) % 65536;
`ifdef TOP_ACC_EN
      e[263:216] = m_acc;
      e[279:264] = 16'(m_cnt);
`endif
      e[362:280] = m_prev;
      m_prev     = {wire3, wire2, wire1, wire0};
      m_chk      = {m_chk[20:0], m_chk[21]} ^ wire0 ^ wire2;
      e[384:363] = m_chk;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input logic [21:0] a, input logic [17:0] b,
                       input logic [21:0] c, input logic [20:0] dd);
    @(negedge clk);
    rst = r; wire0 = a; wire1 = b; wire2 = c; wire3 = dd;
    model_push(r);
  endtask

  task automatic drive_rand(input bit r);
    logic [21:0] a, c;
    logic [17:0] b;
    logic [20:0] dd;
    a  = 22'($urandom);
    b  = 18'($urandom);
    c  = 22'($urandom);
    dd = 21'($urandom);
    case ($urandom_range(0, 5))
      0: c = a;
      1: b = '0;
      2: dd = 21'h100000 | dd;
      default: ;
    endcase
    drive(r, a, b, c, dd);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: result is valid one edge after each driven vector.
  initial begin
    logic [384:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (verbose)
          $display("txn t=%0t rst=%0b in=%0h sum=%0h chk=%0h", $time, rst, y[82:0], y[105:83], y[384:363]);
        cmp("in",   128'(y[82:0]),    128'(e[82:0]));
        cmp("sum",  128'(y[105:83]),  128'(e[105:83]));
        cmp("diff", 128'(y[128:106]), 128'(e[128:106]));
        cmp("prod", 128'(y[160:129]), 128'(e[160:129]));
        cmp("xor",  128'(y[182:161]), 128'(e[182:161]));
        cmp("mux",  128'(y[204:183]), 128'(e[204:183]));
        cmp("flag", 128'(y[208:205]), 128'(e[208:205]));
        cmp("pop",  128'(y[215:209]), 128'(e[215:209]));
        cmp("acc",  128'(y[263:216]), 128'(e[263:216]));
        cmp("cnt",  128'(y[279:264]), 128'(e[279:264]));
        cmp("hist", 128'(y[362:280]), 128'(e[362:280]));
        cmp("chk",  128'(y[384:363]), 128'(e[384:363]));
      end
    end
  end

  initial begin
    logic [82:0] v;
    rst = 1'b1; wire0 = '0; wire1 = '0; wire2 = '0; wire3 = '0;

    // Reset held for two edges.
    drive(1'b1, 22'h3FFFFF, 18'h3FFFF, 22'h12345, 21'h1FFFFF);
    drive(1'b1, 22'h3FFFFF, 18'h3FFFF, 22'h12345, 21'h1FFFFF);
    after_edge();
    cmp("rst_low",  128'(y[362:0] == '0), 128'(1));
    cmp("rst_seed", 128'(y[384:363]), 128'(SEED));

    // Basic arithmetic straight out of reset.
    drive(1'b0, 22'd1, 18'd3, 22'd2, 21'h1FFFFF);
    after_edge();
    cmp("b_sum",  128'(y[105:83]),  128'(23'd3));
    cmp("b_diff", 128'(y[128:106]), 128'(23'h7FFFFC));
    cmp("b_prod", 128'(y[160:129]), 128'(32'd3));
    cmp("b_xor",  128'(y[182:161]), 128'(22'd3));
    cmp("b_mux",  128'(y[204:183]), 128'(22'd1));
    cmp("b_flag", 128'(y[208:205]), 128'(4'b0110));
    cmp("b_pop",  128'(y[215:209]), 128'(7'd25));
`ifdef TOP_ACC_EN
    cmp("b_acc",  128'(y[263:216]), 128'(48'hFFFFFFFFFFFF));
    cmp("b_cnt",  128'(y[279:264]), 128'(16'd1));
`else
    cmp("b_accnt", 128'(y[279:216]), 128'(0));
`endif

    // Overflow corners.
    drive(1'b0, 22'h3FFFFF, 18'h0FFFF, 22'h3FFFFF, 21'h0ABCDE);
    after_edge();
    cmp("o_sum",  128'(y[105:83]),  128'(23'h7FFFFE));
    cmp("o_prod", 128'(y[160:129]), 128'(32'hFFFE0001));
    cmp("o_xor",  128'(y[182:161]), 128'(22'd0));
    cmp("o_eq",   128'(y[208]),     128'(1'b1));

    // Mid-stream reset and history recovery.
    drive_rand(1'b0);
    drive_rand(1'b0);
    drive_rand(1'b0);
    drive(1'b1, 22'h155555, 18'h2AAAA, 22'h0F0F0F, 21'h0F0F0F);
    after_edge();
    cmp("m_rst", 128'(y[362:0] == '0), 128'(1));
    v = {21'h1ACE5, 22'h2BEEF, 18'h1D00D, 22'h3CAFE};
    drive(1'b0, v[21:0], v[39:22], v[61:40], v[82:62]);
    after_edge();
    cmp("m_hist0", 128'(y[362:280]), 128'(0));
    drive_rand(1'b0);
    after_edge();
    cmp("m_hist1", 128'(y[362:280]), 128'(v));

    // Random run with occasional reset.
    for (int i = 0; i < 200; i++) begin
      drive_rand($urandom_range(0, 39) == 0);
    end

    // Counter and accumulator wrap.
    verbose = 1'b0;
    drive(1'b1, 22'd0, 18'd0, 22'd0, 21'd0);
    for (int i = 0; i < 65536; i++) begin
      drive(1'b0, 22'($urandom), 18'($urandom), 22'($urandom), 21'h0FFFFF);
    end
    after_edge();
`ifdef TOP_ACC_EN
    cmp("w_cnt", 128'(y[279:264]), 128'(16'd0));
    cmp("w_acc", 128'(y[263:216]), 128'(48'h000FFFFF0000));
`else
    cmp("w_accnt", 128'(y[279:216]), 128'(0));
`endif
    verbose = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    cmp("drain", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
